// File: rtl/cpu_pkg.sv
// Shared CPU constants and the register-index match helper used by the
// operand forwarding logic.
package cpu_pkg;
  localparam int XLEN           = 64;
  localparam int RIDX           = 6;
  localparam int CTRLW          = 8;
  localparam int CTRL_REG_WRITE = 0;
  localparam int CTRL_MEM_READ  = 1;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // True when a nonzero source index names the same architectural register.
  function automatic logic idx_match(input logic [4:0] src, input logic [4:0] dst);
    return (src != REG_ZERO) && (src == dst);
  endfunction
endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Single-operand forwarding select: x0, then EX/MEM, then MEM/WB, then the
// register file read.
module fwd_mux #(
  parameter int DATA_W = 64,
  parameter int IDX_W  = 6
) (
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [DATA_W-1:0] i_rf_data,
  input  logic              i_exm_valid,
  input  logic [IDX_W-1:0]  i_exm_rd,
  input  logic [DATA_W-1:0] i_exm_data,
  input  logic              i_wb_valid,
  input  logic [IDX_W-1:0]  i_wb_rd,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic [DATA_W-1:0] o_op
);
  import cpu_pkg::*;

  // Bit 5 and above never take part in register matching.
  logic w_unused_hi;
  assign w_unused_hi = ^{i_idx[IDX_W-1:5], i_exm_rd[IDX_W-1:5], i_wb_rd[IDX_W-1:5]};

  always_comb begin
    o_op = i_rf_data;
    if (i_idx[4:0] == REG_ZERO) begin
      o_op = '0;
    end else if (i_exm_valid && idx_match(i_idx[4:0], i_exm_rd[4:0])) begin
      o_op = i_exm_data;
    end else if (i_wb_valid && idx_match(i_idx[4:0], i_wb_rd[4:0])) begin
      o_op = i_wb_data;
    end
  end
endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use bubble insertion
// and a valid/ready handshake towards execute.
module id_ex_stage #(
  parameter int XLEN  = cpu_pkg::XLEN,
  parameter int RIDX  = cpu_pkg::RIDX,
  parameter int CTRLW = cpu_pkg::CTRLW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [RIDX-1:0]  in_rs1,
  input  logic [RIDX-1:0]  in_rs2,
  input  logic [RIDX-1:0]  in_rd,
  input  logic [XLEN-1:0]  in_data1,
  input  logic [XLEN-1:0]  in_data2,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [CTRLW-1:0] in_ctrl,
  input  logic             flush,
  input  logic             exm_fwd_valid,
  input  logic [RIDX-1:0]  exm_fwd_rd,
  input  logic [XLEN-1:0]  exm_fwd_data,
  input  logic             wb_fwd_valid,
  input  logic [RIDX-1:0]  wb_fwd_rd,
  input  logic [XLEN-1:0]  wb_fwd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RIDX-1:0]  out_rs1,
  output logic [RIDX-1:0]  out_rs2,
  output logic [RIDX-1:0]  out_rd,
  output logic [XLEN-1:0]  out_op_a,
  output logic [XLEN-1:0]  out_op_b,
  output logic [XLEN-1:0]  out_imm,
  output logic [CTRLW-1:0] out_ctrl,
  output logic [31:0]      stall_cnt
);
  import cpu_pkg::*;

  logic             r_valid;
  logic [RIDX-1:0]  r_rs1;
  logic [RIDX-1:0]  r_rs2;
  logic [RIDX-1:0]  r_rd;
  logic [XLEN-1:0]  r_op_a;
  logic [XLEN-1:0]  r_op_b;
  logic [XLEN-1:0]  r_imm;
  logic [CTRLW-1:0] r_ctrl;
  logic [31:0]      r_stall_cnt;

  logic [XLEN-1:0]  w_sel_a;
  logic [XLEN-1:0]  w_sel_b;
  logic             w_hazard;
  logic             w_ready;
  logic             w_capture;
  logic             w_refresh_a;
  logic             w_refresh_b;
  logic             w_stall_inc;

  fwd_mux #(.DATA_W(XLEN), .IDX_W(RIDX)) u_fwd_a (
    .i_idx       (in_rs1),
    .i_rf_data   (in_data1),
    .i_exm_valid (exm_fwd_valid),
    .i_exm_rd    (exm_fwd_rd),
    .i_exm_data  (exm_fwd_data),
    .i_wb_valid  (wb_fwd_valid),
    .i_wb_rd     (wb_fwd_rd),
    .i_wb_data   (wb_fwd_data),
    .o_op        (w_sel_a)
  );

  fwd_mux #(.DATA_W(XLEN), .IDX_W(RIDX)) u_fwd_b (
    .i_idx       (in_rs2),
    .i_rf_data   (in_data2),
    .i_exm_valid (exm_fwd_valid),
    .i_exm_rd    (exm_fwd_rd),
    .i_exm_data  (exm_fwd_data),
    .i_wb_valid  (wb_fwd_valid),
    .i_wb_rd     (wb_fwd_rd),
    .i_wb_data   (wb_fwd_data),
    .o_op        (w_sel_b)
  );

  // A load in the entry cannot forward its data yet, so a dependent consumer waits.
  assign w_hazard = r_valid && r_ctrl[CTRL_MEM_READ] &&
                    (r_rd[4:0] != REG_ZERO) &&
                    ((r_rd[4:0] == in_rs1[4:0]) || (r_rd[4:0] == in_rs2[4:0]));

  assign w_ready     = (!r_valid || out_ready) && !w_hazard;
  assign w_capture   = in_valid && w_ready && !flush;
  assign w_stall_inc = in_valid && w_hazard && out_ready && !flush;

  // A held entry picks up register file writes that land while it waits.
  assign w_refresh_a = wb_fwd_valid && idx_match(r_rs1[4:0], wb_fwd_rd[4:0]);
  assign w_refresh_b = wb_fwd_valid && idx_match(r_rs2[4:0], wb_fwd_rd[4:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd    <= '0;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_imm   <= '0;
      r_ctrl  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (w_capture) begin
      r_valid <= 1'b1;
      r_rs1   <= in_rs1;
      r_rs2   <= in_rs2;
      r_rd    <= in_rd;
      r_op_a  <= w_sel_a;
      r_op_b  <= w_sel_b;
      r_imm   <= in_imm;
      r_ctrl  <= in_ctrl;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (r_valid) begin
      if (w_refresh_a) r_op_a <= wb_fwd_data;
      if (w_refresh_b) r_op_b <= wb_fwd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall_inc) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign in_ready  = w_ready;
  assign out_valid = r_valid;
  assign out_rs1   = r_rs1;
  assign out_rs2   = r_rs2;
  assign out_rd    = r_rd;
  assign out_op_a  = r_op_a;
  assign out_op_b  = r_op_b;
  assign out_imm   = r_imm;
  assign out_ctrl  = r_ctrl;
  assign stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected entries are queued at capture
// and compared when execute consumes them.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic [63:0] in_data1 = '0, in_data2 = '0, in_imm = '0;
  logic [7:0]  in_ctrl = '0;
  logic        flush = 1'b0;
  logic        exm_fwd_valid = 1'b0;
  logic [5:0]  exm_fwd_rd = '0;
  logic [63:0] exm_fwd_data = '0;
  logic        wb_fwd_valid = 1'b0;
  logic [5:0]  wb_fwd_rd = '0;
  logic [63:0] wb_fwd_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [5:0]  out_rs1, out_rs2, out_rd;
  logic [63:0] out_op_a, out_op_b, out_imm;
  logic [7:0]  out_ctrl;
  logic [31:0] stall_cnt;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_data1(in_data1), .in_data2(in_data2), .in_imm(in_imm), .in_ctrl(in_ctrl),
    .flush(flush),
    .exm_fwd_valid(exm_fwd_valid), .exm_fwd_rd(exm_fwd_rd), .exm_fwd_data(exm_fwd_data),
    .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_op_a(out_op_a), .out_op_b(out_op_b), .out_imm(out_imm),
    .out_ctrl(out_ctrl), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  rs1, rs2, rd;
    logic [63:0] a, b, imm;
    logic [7:0]  ctrl;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int   total = 0;
  int   bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference operand select from the current forwarding inputs.
  function automatic logic [63:0] fsel(input logic [5:0] idx, input logic [63:0] rf);
    if (idx[4:0] == 5'd0) return 64'd0;
    if (exm_fwd_valid && exm_fwd_rd[4:0] == idx[4:0]) return exm_fwd_data;
    if (wb_fwd_valid && wb_fwd_rd[4:0] == idx[4:0]) return wb_fwd_data;
    return rf;
  endfunction

  // Consumer side: pop on handshake; track held-entry refresh otherwise.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("unexpected_out", 64'd1, 64'd0);
        end else begin
          e_mon = q.pop_front();
          check("out_op_a", out_op_a, e_mon.a);
          check("out_op_b", out_op_b, e_mon.b);
          check("out_imm", out_imm, e_mon.imm);
          check("out_rd", {58'd0, out_rd}, {58'd0, e_mon.rd});
          check("out_ctrl", {56'd0, out_ctrl}, {56'd0, e_mon.ctrl});
        end
      end else if (out_valid && wb_fwd_valid && q.size() > 0) begin
        if (wb_fwd_rd[4:0] != 5'd0 && wb_fwd_rd[4:0] == q[0].rs1[4:0]) q[0].a = wb_fwd_data;
        if (wb_fwd_rd[4:0] != 5'd0 && wb_fwd_rd[4:0] == q[0].rs2[4:0]) q[0].b = wb_fwd_data;
      end
    end
  end

  // Drive one instruction, wait (bounded) for acceptance, queue its expectation.
  task automatic send(input logic [5:0] rs1, input logic [5:0] rs2, input logic [5:0] rd,
                      input logic [63:0] d1, input logic [63:0] d2, input logic [63:0] imm,
                      input logic [7:0] ctrl, output int waits);
    exp_t e;
    in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_data1 = d1; in_data2 = d2; in_imm = imm; in_ctrl = ctrl;
    in_valid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 10) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("send_timeout", 64'd0, 64'd1);
    end else begin
      e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
      e.a = fsel(rs1, d1); e.b = fsel(rs2, d2);
      e.imm = imm; e.ctrl = ctrl;
      q.push_back(e);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got=0 exp=1");
    $fatal(1, "bench timeout");
  end

  initial begin
    int w;
    logic [5:0]  r1, r2;
    logic [63:0] d1, d2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_stall_cnt", {32'd0, stall_cnt}, 64'd0);
    check("rst_out_op_a", out_op_a, 64'd0);
    check("rst_out_ctrl", {56'd0, out_ctrl}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send(6'd3, 6'd4, 6'd1, 64'h1111, 64'h2222, 64'h10, 8'h01, w);
    check("pass_valid_next", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;

    // Forwarding priority, including index bit 5 being ignored.
    exm_fwd_valid = 1'b1; exm_fwd_rd = 6'd5; exm_fwd_data = 64'hAAAA;
    wb_fwd_valid  = 1'b1; wb_fwd_rd  = 6'd5; wb_fwd_data  = 64'hBBBB;
    send(6'd5, 6'd2, 6'd1, 64'hCCCC, 64'h22, 64'h0, 8'h01, w);
    send(6'h25, 6'd2, 6'd1, 64'hCCCC, 64'h22, 64'h0, 8'h01, w);
    exm_fwd_valid = 1'b0;
    send(6'd5, 6'd2, 6'd1, 64'hCCCC, 64'h22, 64'h0, 8'h01, w);
    exm_fwd_valid = 1'b1; exm_fwd_rd = 6'd0; wb_fwd_rd = 6'd0;
    send(6'd0, 6'd2, 6'd1, 64'hCCCC, 64'h22, 64'h0, 8'h01, w);
    exm_fwd_valid = 1'b0; wb_fwd_valid = 1'b0;
    @(posedge clk); #1;

    // Load-use: one bubble, then the dependent instruction is taken.
    send(6'd1, 6'd2, 6'd7, 64'h5, 64'h6, 64'h0, 8'h03, w);
    in_rs1 = 6'd8; in_rs2 = 6'd7; in_rd = 6'd9;
    in_data1 = 64'h88; in_data2 = 64'h77; in_imm = 64'h4; in_ctrl = 8'h01;
    in_valid = 1'b1;
    @(negedge clk);
    check("lu_ready_low", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    check("lu_bubble_valid", {63'd0, out_valid}, 64'd0);
    check("lu_bubble_ctrl", {56'd0, out_ctrl}, 64'd0);
    check("lu_stall_cnt", {32'd0, stall_cnt}, 64'd1);
    check("lu_ready_back", {63'd0, in_ready}, 64'd1);
    q.push_back('{rs1: 6'd8, rs2: 6'd7, rd: 6'd9, a: 64'h88, b: 64'h77, imm: 64'h4, ctrl: 8'h01});
    @(posedge clk); #1 in_valid = 1'b0;
    @(posedge clk); #1;

    // Hold with register-file refresh of the held operand.
    out_ready = 1'b0;
    send(6'd9, 6'd2, 6'd3, 64'h1, 64'h2, 64'h0, 8'h01, w);
    wb_fwd_valid = 1'b1; wb_fwd_rd = 6'd9; wb_fwd_data = 64'h99;
    @(negedge clk);
    check("hold_before_refresh", out_op_a, 64'h1);
    @(negedge clk);
    check("hold_refreshed", out_op_a, 64'h99);
    check("hold_still_valid", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;
    wb_fwd_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;

    // Flush beats a load-use hazard and must not count a stall.
    send(6'd1, 6'd2, 6'd7, 64'h10, 64'h20, 64'h0, 8'h07, w);
    in_rs1 = 6'd7; in_rs2 = 6'd0; in_ctrl = 8'hFF; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("flush_hz_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_hz_valid", {63'd0, out_valid}, 64'd0);
    check("flush_hz_ctrl", {56'd0, out_ctrl}, 64'd0);
    check("flush_hz_stall", {32'd0, stall_cnt}, 64'd1);
    // Flush beats a capture the stage would otherwise accept.
    @(posedge clk); #1;
    in_rs1 = 6'd3; in_ctrl = 8'hFF; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("flush_cap_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1 in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_cap_valid", {63'd0, out_valid}, 64'd0);
    check("flush_cap_ctrl", {56'd0, out_ctrl}, 64'd0);
    check("flush_cap_stall", {32'd0, stall_cnt}, 64'd1);
    @(posedge clk); #1;

    // Random non-load traffic with random forwarding.
    for (int i = 0; i < 20; i++) begin
      exm_fwd_valid = 1'($urandom_range(0, 1));
      exm_fwd_rd    = 6'($urandom_range(0, 7));
      exm_fwd_data  = {$urandom, $urandom};
      wb_fwd_valid  = 1'($urandom_range(0, 1));
      wb_fwd_rd     = 6'($urandom_range(0, 7));
      wb_fwd_data   = {$urandom, $urandom};
      r1 = 6'($urandom_range(0, 7));
      r2 = 6'($urandom_range(0, 7)) | 6'($urandom_range(0, 1) << 5);
      d1 = {$urandom, $urandom};
      d2 = {$urandom, $urandom};
      send(r1, r2, 6'($urandom_range(0, 31)), d1, d2, {$urandom, $urandom},
           8'($urandom) & 8'hFD, w);
    end
    exm_fwd_valid = 1'b0; wb_fwd_valid = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset while an entry is held.
    out_ready = 1'b0;
    send(6'd1, 6'd2, 6'd7, 64'h55, 64'h66, 64'h0, 8'h03, w);
    check("pre_reset_valid", {63'd0, out_valid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("areset_valid", {63'd0, out_valid}, 64'd0);
    check("areset_stall", {32'd0, stall_cnt}, 64'd0);
    check("areset_op_a", out_op_a, 64'd0);
    check("areset_in_ready", {63'd0, in_ready}, 64'd1);
    q.delete();
    @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
    send(6'd3, 6'd4, 6'd5, 64'h123, 64'h456, 64'h7, 8'h01, w);
    repeat (3) @(posedge clk);
    #1;
    check("drain", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
